// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 keyboard receiver with make/break decoding, repeat filtering and an event FIFO.
// Optional frame timeout is enabled by defining PS2_KBD_TIMEOUT_EN.
module ps2_kbd_rx #(
  parameter int FIFO_DEPTH  = 8,
  parameter int CNT_W       = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ps2_clk,
  input  logic             ps2_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [7:0]       key,
  output logic             is_ext,
  output logic             is_press,
  output logic [CNT_W-1:0] count,
  output logic             frame_err,
  output logic             overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} st_t;
  logic [1:0] c_sync, d_sync;
  logic c_prev, fall, frame_ok, tout;
  logic [3:0] bcnt;
  logic [10:0] shreg, nf;
  logic byte_vld;
  logic [7:0] rx_byte;
  st_t st;
  logic held_v, held_ext;
  logic [7:0] held_code;
  logic is_e0, is_f0, ev_ext, ev_press, match, push, pop, full;
  logic [9:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic [9:0] head;
  assign fall     = c_prev & ~c_sync[1];
  assign nf       = {d_sync[1], shreg[10:1]};
  assign frame_ok = ~nf[0] & nf[10] & (^nf[9:1]);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      c_sync <= 2'b11;
      d_sync <= 2'b11;
      c_prev <= 1'b1;
    end else begin
      c_sync <= {c_sync[0], ps2_clk};
      d_sync <= {d_sync[0], ps2_data};
      c_prev <= c_sync[1];
    end
`ifdef PS2_KBD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  logic [TW-1:0] tcnt;
  assign tout = (bcnt != 4'd0) && (tcnt == TW'(TIMEOUT_CYC - 1));
  always_ff @(posedge clk or posedge rst)
    if (rst) tcnt <= '0;
    else tcnt <= (fall || bcnt == 4'd0 || tout) ? '0 : tcnt + TW'(1);
`else
  assign tout = 1'b0;
`endif
  // Bit 10 is the stop bit; the whole frame is judged on that edge.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bcnt      <= '0;
      shreg     <= '0;
      rx_byte   <= '0;
      byte_vld  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      byte_vld  <= 1'b0;
      frame_err <= 1'b0;
      if (fall) begin
        shreg <= nf;
        if (bcnt == 4'd10) begin
          bcnt      <= '0;
          byte_vld  <= frame_ok;
          frame_err <= ~frame_ok;
          rx_byte   <= nf[8:1];
        end else bcnt <= bcnt + 4'd1;
      end else if (tout) begin
        bcnt      <= '0;
        frame_err <= 1'b1;
      end
    end
  assign is_e0    = rx_byte == 8'hE0;
  assign is_f0    = rx_byte == 8'hF0;
  assign ev_ext   = st == EXT || st == EXT_BRK;
  assign ev_press = st == IDLE || st == EXT;
  assign match    = held_v && held_ext == ev_ext && held_code == rx_byte;
  assign push     = byte_vld && !is_e0 && !is_f0 && !(ev_press && match);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st        <= IDLE;
      held_v    <= 1'b0;
      held_ext  <= 1'b0;
      held_code <= '0;
      count     <= '0;
    end else if (byte_vld) begin
      if (is_e0) st <= (st == BRK || st == EXT_BRK) ? EXT_BRK : EXT;
      else if (is_f0) st <= (st == EXT || st == EXT_BRK) ? EXT_BRK : BRK;
      else begin
        st <= IDLE;
        if (ev_press && !match) begin
          held_v    <= 1'b1;
          held_ext  <= ev_ext;
          held_code <= rx_byte;
          count     <= count + CNT_W'(1);
        end
        if (!ev_press && match) held_v <= 1'b0;
      end
    end
  assign out_valid = wr_ptr != rd_ptr;
  assign full      = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
  assign pop       = out_valid && out_ready;
  assign head      = out_valid ? mem[rd_ptr[AW-1:0]] : '0;
  assign {is_ext, is_press, key} = head;
  always_ff @(posedge clk)
    if (push && (!full || pop)) mem[wr_ptr[AW-1:0]] <= {ev_ext, ev_press, rx_byte};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
      if (push && (!full || pop)) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (push && full && !pop) overflow <= 1'b1;
    end
endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb_ps2_kbd_rx: table vectors, timing corner sequences and randomized byte streams vs a behavioural model.
module tb_ps2_kbd_rx;
  localparam int DEPTH = 8;
  localparam int TOUT  = 200;
  logic clk = 0, rst = 1, ps2_clk = 1, ps2_data = 1, out_ready = 0;
  logic out_valid, is_ext, is_press, frame_err, overflow;
  logic [7:0] key, count;
  ps2_kbd_rx #(.FIFO_DEPTH(DEPTH), .CNT_W(8), .TIMEOUT_CYC(TOUT)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .out_ready(out_ready),
    .out_valid(out_valid), .key(key), .is_ext(is_ext), .is_press(is_press),
    .count(count), .frame_err(frame_err), .overflow(overflow));
  always #5 clk = ~clk;
  int checks = 0, errors = 0, err_seen = 0;
  always @(posedge clk) if (frame_err) err_seen++;
  bit m_ext, m_brk, h_v, h_ext, m_ovf;
  logic [7:0] h_code;
  logic [9:0] q[$];
  logic [9:0] act[$];
  int m_count, exp_err;
  typedef struct { logic [47:0] seq; int nb; int nev; logic [9:0] last; int cnt; } vec_t;
  vec_t tbl[7];
  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, a, e);
    end
  endtask
  task automatic model_reset();
    m_ext = 0; m_brk = 0; h_v = 0; h_ext = 0; h_code = 0; m_ovf = 0; m_count = 0;
    q.delete();
  endtask
  task automatic model_push(input logic [9:0] ev);
    if (q.size() < DEPTH) q.push_back(ev);
    else m_ovf = 1;
  endtask
  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      if (!m_brk) begin
        if (!(h_v && h_ext == m_ext && h_code == b)) begin
          h_v = 1; h_ext = m_ext; h_code = b; m_count++;
          model_push({m_ext, 1'b1, b});
        end
      end else begin
        model_push({m_ext, 1'b0, b});
        if (h_v && h_ext == m_ext && h_code == b) h_v = 0;
      end
      m_ext = 0; m_brk = 0;
    end
  endtask
  function automatic logic [10:0] mkframe(input logic [7:0] b, input bit bad);
    return {1'b1, (~^b) ^ bad, b, 1'b0};
  endfunction
  task automatic bits(input logic [10:0] f, input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      @(negedge clk) ps2_data = f[i];
      repeat (3) @(negedge clk);
      ps2_clk = 0;
      repeat (4) @(negedge clk);
      ps2_clk = 1;
    end
  endtask
  task automatic send(input logic [7:0] b, input bit bad);
    bits(mkframe(b, bad), 0, 11);
    repeat (6) @(negedge clk);
    if (bad) exp_err++;
    else model_byte(b);
  endtask
  // Leaves the stop-bit falling edge just driven at a negedge.
  task automatic to_stop_edge(input logic [7:0] b);
    bits(mkframe(b, 0), 0, 10);
    @(negedge clk) ps2_data = 1;
    repeat (3) @(negedge clk);
    ps2_clk = 0;
  endtask
  task automatic do_reset();
    @(negedge clk) rst = 1; ps2_clk = 1; ps2_data = 1; out_ready = 0;
    @(negedge clk) rst = 0;
    model_reset();
    exp_err = err_seen;
  endtask
  task automatic drain();
    act.delete();
    for (int i = 0; i < 2 * DEPTH && out_valid; i++) begin
      act.push_back({is_ext, is_press, key});
      out_ready = 1;
      @(negedge clk) out_ready = 0;
    end
  endtask
  task automatic check_model(input int batch);
    chk($sformatf("b%0d_count", batch), count, m_count[7:0]);
    chk($sformatf("b%0d_ovf", batch), overflow, m_ovf);
    chk($sformatf("b%0d_err", batch), err_seen, exp_err);
    drain();
    chk($sformatf("b%0d_nev", batch), act.size(), q.size());
    for (int i = 0; i < act.size() && i < q.size(); i++)
      chk($sformatf("b%0d_ev%0d", batch, i), act[i], q[i]);
    q.delete();
  endtask
  initial begin
    logic [7:0] pool [6];
    logic [47:0] s;
    int e0;
    pool[0] = 8'h1C; pool[1] = 8'h1D; pool[2] = 8'h75; pool[3] = 8'hE0; pool[4] = 8'hF0; pool[5] = 8'h5A;
    tbl[0] = '{48'h00_00_00_1C_F0_1C, 3, 2, 10'h01C, 1};
    tbl[1] = '{48'h00_75_F0_E0_75_E0, 5, 2, 10'h275, 1};
    tbl[2] = '{48'h00_00_00_1C_1C_1C, 3, 1, 10'h11C, 1};
    tbl[3] = '{48'h00_00_00_75_E0_E0, 3, 1, 10'h375, 1};
    tbl[4] = '{48'h00_00_00_75_E0_F0, 3, 1, 10'h275, 0};
    tbl[5] = '{48'h00_00_1C_1C_F0_1C, 4, 3, 10'h11C, 2};
    tbl[6] = '{48'h00_00_00_1C_E0_1C, 3, 2, 10'h31C, 2};
    repeat (3) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_key", key, 0);
    chk("rst_ext", is_ext, 0);
    chk("rst_press", is_press, 0);
    chk("rst_count", count, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_ovf", overflow, 0);
    @(negedge clk) rst = 0;
    model_reset();
    exp_err = err_seen;
    for (int t = 0; t < 7; t++) begin
      do_reset();
      s = tbl[t].seq;
      for (int i = 0; i < tbl[t].nb; i++) send(s[8*i +: 8], 0);
      drain();
      chk($sformatf("t%0d_nev", t), act.size(), tbl[t].nev);
      chk($sformatf("t%0d_last", t), act.size() > 0 ? act[act.size()-1] : 10'h3FF, tbl[t].last);
      chk($sformatf("t%0d_count", t), count, tbl[t].cnt);
      if (t == 0) chk("t0_first", act.size() > 0 ? act[0] : 10'h3FF, 10'h11C);
    end
    do_reset();
    e0 = err_seen;
    send(8'h1C, 1);
    chk("par_err", err_seen - e0, 1);
    chk("par_valid", out_valid, 0);
    chk("par_count", count, 0);
    do_reset();
    to_stop_edge(8'h1C);
    repeat (3) @(negedge clk);
    chk("lat_valid_early", out_valid, 0);
    @(negedge clk);
    chk("lat_valid", out_valid, 1);
    chk("lat_key", key, 8'h1C);
    ps2_clk = 1;
    repeat (6) @(negedge clk);
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) send(8'h10 + 8'(i), 0);
    chk("ovf_flag", overflow, 1);
    chk("ovf_count", count, DEPTH + 1);
    drain();
    chk("ovf_nev", act.size(), DEPTH);
    chk("ovf_head", act.size() > 0 ? act[0] : 10'h3FF, 10'h110);
    chk("ovf_tail", act.size() > 0 ? act[act.size()-1] : 10'h3FF, 10'h117);
    do_reset();
    for (int i = 0; i < DEPTH; i++) send(8'h10 + 8'(i), 0);
    to_stop_edge(8'h30);
    repeat (3) @(negedge clk);
    out_ready = 1;
    @(negedge clk) out_ready = 0;
    ps2_clk = 1;
    repeat (6) @(negedge clk);
    chk("fullpop_ovf", overflow, 0);
    drain();
    chk("fullpop_nev", act.size(), DEPTH);
    chk("fullpop_head", act.size() > 0 ? act[0] : 10'h3FF, 10'h111);
    chk("fullpop_tail", act.size() > 0 ? act[act.size()-1] : 10'h3FF, 10'h130);
    do_reset();
    send(8'h1C, 0);
    bits(mkframe(8'h1D, 0), 0, 5);
    @(posedge clk) #2 rst = 1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_count", count, 0);
    @(negedge clk) rst = 0;
    model_reset();
    send(8'h1C, 0);
    drain();
    chk("midrst_nev", act.size(), 1);
    chk("midrst_ev", act.size() > 0 ? act[0] : 10'h3FF, 10'h11C);
`ifdef PS2_KBD_TIMEOUT_EN
    do_reset();
    e0 = err_seen;
    send(8'hE0, 0);
    bits(mkframe(8'h1D, 0), 0, 5);
    repeat (TOUT + 20) @(negedge clk);
    chk("tout_err", err_seen - e0, 1);
    send(8'h75, 0);
    drain();
    chk("tout_nev", act.size(), 1);
    chk("tout_ev", act.size() > 0 ? act[0] : 10'h3FF, 10'h375);
`else
    do_reset();
    e0 = err_seen;
    bits(mkframe(8'h1C, 0), 0, 5);
    repeat (TOUT + 100) @(negedge clk);
    bits(mkframe(8'h1C, 0), 5, 11);
    repeat (6) @(negedge clk);
    chk("stall_err", err_seen - e0, 0);
    drain();
    chk("stall_nev", act.size(), 1);
    chk("stall_ev", act.size() > 0 ? act[0] : 10'h3FF, 10'h11C);
`endif
    do_reset();
    for (int b = 0; b < 30; b++) begin
      int n;
      n = $urandom_range(1, 10);
      for (int i = 0; i < n; i++) send(pool[$urandom_range(0, 5)], $urandom_range(0, 9) == 0);
      check_model(b);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ps2_kbd_rx.md
PS2_KBD_RX -- requirements
Module: ps2_kbd_rx

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 8, meaning the number of event FIFO entries (power of 2, at least 2).
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning the width of the key-press counter.
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 50000, meaning the clk cycles allowed between ps2_clk falling edges inside a frame.
REQ-004 clk  in  1  system clock; all state SHALL be updated on its rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-high.
REQ-006 ps2_clk  in  1  raw keyboard clock, asynchronous to clk.
REQ-007 ps2_data  in  1  raw keyboard data, asynchronous to clk.
REQ-008 out_ready  in  1  consumer accepts the head event.
REQ-009 out_valid  out  1  FIFO non-empty; head event present.
REQ-010 key  out  8  scan code of the head event.
REQ-011 is_ext  out  1  head event was E0-prefixed.
REQ-012 is_press  out  1  head event is a make (1) or a break (0).
REQ-013 count  out  CNT_W  number of non-repeat make events, modulo 2^CNT_W.
REQ-014 frame_err  out  1  one-cycle pulse when a frame is rejected.
REQ-015 overflow  out  1  sticky flag: an event was dropped because the FIFO was full.

Function
REQ-016 ps2_clk and ps2_data SHALL each pass through a 2-FF synchronizer; a falling edge SHALL be detected when the previous synchronized ps2_clk is 1 and the current one is 0.
REQ-017 On each falling edge, synchronized ps2_data SHALL be sampled into an 11-bit frame (start, 8 data bits LSB first, parity, stop), tracked by a bit counter 0..10.
REQ-018 After bit 10 the frame SHALL be accepted only if start=0, stop=1 and data plus parity have odd parity; otherwise it SHALL be dropped and frame_err pulsed in the next cycle.
REQ-019 The decoder FSM SHALL use states IDLE, EXT, BRK and EXT_BRK.
REQ-020 Decoder transitions on an accepted byte: E0 from IDLE->EXT, from BRK->EXT_BRK; F0 from IDLE->BRK, from EXT->EXT_BRK; a prefix byte that is already in effect SHALL hold the current state.
REQ-021 Any other accepted byte SHALL form event {ext, press, code}, with ext=1 in EXT/EXT_BRK and press=0 in BRK/EXT_BRK, and the FSM SHALL return to IDLE.
REQ-022 A held-key register {valid, ext, code} SHALL track the last make; a make equal to the held key is a typematic repeat and SHALL be discarded, not pushed and not counted.
REQ-023 A non-repeat make SHALL load the held register, increment count (wrapping at 2^CNT_W) and be pushed; this applies even if the push is dropped.
REQ-024 A break SHALL be pushed and SHALL clear held.valid when it matches the held key.
REQ-025 Event push SHALL occur in the cycle after the stop-bit edge is detected, and out_valid SHALL rise in the following cycle, giving a latency of 2 cycles from the stop edge.
REQ-026 A pop SHALL occur when out_valid && out_ready; key, is_ext and is_press SHALL then show the next entry in the next cycle.
REQ-027 A push when full SHALL be dropped and set overflow, unless a pop occurs in the same cycle, in which case both the pop and the push SHALL complete.
REQ-028 A simultaneous push and pop when the FIFO is empty SHALL leave the pushed event visible on the next cycle.
REQ-029 The FIFO pointers SHALL wrap modulo FIFO_DEPTH, with full and empty distinguished by an extra pointer bit.

Reset
REQ-030 Asserting rst SHALL, at any time including mid-frame, clear the synchronizers to 1, the bit counter, the FSM (to IDLE), the held register, the FIFO pointers and the timeout counter.
REQ-031 Asserting rst SHALL set out_valid=0, key=0, is_ext=0, is_press=0, count=0, frame_err=0 and overflow=0.
REQ-032 A partial frame in progress at reset SHALL be discarded.

Configuration
REQ-033 With macro PS2_KBD_TIMEOUT_EN defined, a counter SHALL run while the bit counter is non-zero and restart on each falling edge.
REQ-034 With PS2_KBD_TIMEOUT_EN defined, when that counter reaches TIMEOUT_CYC-1 the frame SHALL be aborted, the bit counter zeroed and frame_err pulsed, with the decoder state left unchanged.
REQ-035 Without PS2_KBD_TIMEOUT_EN, no timeout logic SHALL exist and a stalled frame SHALL wait indefinitely.

Verification
REQ-036 Frames 1C, F0 1C -> events {0,1,1C} then {0,0,1C}; count=1.
REQ-037 Frames E0 75, E0 F0 75 -> events {1,1,75} then {1,0,75}.
REQ-038 Frames 1C, 1C, 1C (typematic repeat) -> exactly one event; count=1.
REQ-039 Frame 1C with even parity -> frame_err pulses once, no event is pushed, and count is unchanged.
REQ-040 With out_ready=0, send FIFO_DEPTH+1 distinct makes -> FIFO_DEPTH events are retained, overflow=1, count=FIFO_DEPTH+1.
REQ-041 With PS2_KBD_TIMEOUT_EN defined, send 5 bits then stall TIMEOUT_CYC cycles -> frame_err pulses; a following frame 1C is decoded correctly.
